// File: rtl/ysyx_220578_fetch_ctrl_pkg.sv
// Shared definitions for the NPC fetch controller: reset PC and fetch FSM encodings.
package ysyx_220578_fetch_ctrl_pkg;

    // First fetch address after reset.
    localparam logic [63:0] YSYX_220578_RESET_PC = 64'h0000_0000_8000_0000;

    // Fetch sequencing states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ysyx_220578_pc_reg.sv
// Program counter register with asynchronous reset, load and +4 increment.
module ysyx_220578_pc_reg
    import ysyx_220578_fetch_ctrl_pkg::*;
#(
    parameter int unsigned               ADDR_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0]     RESET_PC   = ADDR_WIDTH'(YSYX_220578_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_en_i,
    input  logic [ADDR_WIDTH-1:0] load_pc_i,
    input  logic                  inc_en_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_d, pc_q;

    // Load wins over increment; the increment wraps at the address width.
    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = load_pc_i;
        end else if (inc_en_i) begin
            pc_d = pc_q + ADDR_WIDTH'(4);
        end
    end

    // PC state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_220578_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// buffers the response and hands {inst, pc} to the IDU; EXU redirects discard stale fetches.
module ysyx_220578_fetch_ctrl
    import ysyx_220578_fetch_ctrl_pkg::*;
#(
    parameter int unsigned               ADDR_WIDTH = 64,
    parameter int unsigned               INST_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]     RESET_PC   = ADDR_WIDTH'(YSYX_220578_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_req_ready,
    input  logic                  imem_resp_valid,
    input  logic [INST_WIDTH-1:0] imem_resp_inst,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    output logic [63:0]           fetch_cnt
);

    fetch_state_e          state_d, state_q;
    logic                  flush_d, flush_q;
    logic [INST_WIDTH-1:0] inst_d, inst_q;
    logic [63:0]           fetch_cnt_d, fetch_cnt_q;
    logic                  pc_load, pc_inc;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] redirect_pc_aligned;

    assign redirect_pc_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    ysyx_220578_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_en_i (pc_load),
        .load_pc_i (redirect_pc_aligned),
        .inc_en_i  (pc_inc),
        .pc_o      (pc)
    );

    // Next-state logic for the fetch FSM, flush flag, instruction buffer and counter.
    always_comb begin
        state_d     = state_q;
        flush_d     = flush_q;
        inst_d      = inst_q;
        fetch_cnt_d = fetch_cnt_q;
        pc_load     = 1'b0;
        pc_inc      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                pc_load = redirect_valid;
                state_d = S_REQ;
            end
            S_REQ: begin
                pc_load = redirect_valid;
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                    // Memory already latched the old address; its reply must be dropped.
                    if (redirect_valid) begin
                        flush_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                pc_load = redirect_valid;
                if (redirect_valid) begin
                    flush_d = 1'b1;
                end
                if (imem_resp_valid) begin
                    if (flush_q || redirect_valid) begin
                        flush_d = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = imem_resp_inst;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_inc      = 1'b1;
                    fetch_cnt_d = fetch_cnt_q + 64'd1;
                    state_d     = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Fetch control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            flush_q     <= 1'b0;
            inst_q      <= '0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_q     <= flush_d;
            inst_q      <= inst_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_req_valid = (state_q == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state_q == S_OUT);
    assign inst_out       = inst_q;
    assign inst_pc        = pc;
    assign fetch_cnt      = fetch_cnt_q;

endmodule
